// File: rtl/pgm_mem_pkg.sv
// Shared constants and types for the PGM SDRAM fetch arbiters.
package pgm_mem_pkg;

  localparam int unsigned SDRAM_ADDR_W = 29;
  localparam int unsigned GRANT_W      = 3;

  localparam int unsigned REQ_68K = 0;
  localparam int unsigned REQ_Z80 = 1;
  localparam int unsigned REQ_ICS = 2;

  localparam logic [SDRAM_ADDR_W-1:0] W_ROM_BASE = 29'h620000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector with optional fixed-priority override.
module rr_pick
  import pgm_mem_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [GRANT_W-1:0] rr,
  input  logic               prio_en,
  input  logic [GRANT_W-1:0] prio_req,
  output logic               valid,
  output logic [GRANT_W-1:0] index
);

  logic [7:0] req_pad;
  logic [3:0] cand;
  logic       found;

  assign req_pad = 8'(req);

  // Scan from rr upward, wrapping at N_REQ; priority requester overrides.
  always_comb begin
    valid = |req;
    index = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 4'(rr) + 4'(k);
      if (cand >= 4'(N_REQ)) begin
        cand = cand - 4'(N_REQ);
      end
      if (!found && req_pad[cand[2:0]]) begin
        index = cand[2:0];
        found = 1'b1;
      end
    end
    if (prio_en && req_pad[prio_req]) begin
      index = prio_req;
    end
  end

endmodule

// File: rtl/pgm_sdram_rd_arb.sv
// Shares the 64-bit SDRAM read port between N_REQ level-held requesters,
// one outstanding read, with a watchdog that aborts stalled reads.
module pgm_sdram_rd_arb
  import pgm_mem_pkg::*;
#(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned ADDR_W   = SDRAM_ADDR_W,
  parameter int unsigned PRIO_REQ = REQ_68K,
  parameter int unsigned PRIO_EN  = 0,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          ack,
  output logic [63:0]               rdata,
  output logic                      err,
  output logic [GRANT_W-1:0]        grant_id,
  output logic                      busy,
  output logic                      sdram_rd,
  output logic [ADDR_W-1:0]         sdram_addr,
  input  logic [63:0]               sdram_dout,
  input  logic                      sdram_busy,
  input  logic                      sdram_dout_ready
);

  localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

  arb_state_e          state_q, state_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                err_q, err_d;
  logic [63:0]         rdata_q, rdata_d;
  logic [GRANT_W-1:0]  grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [GRANT_W-1:0]  rr_q, rr_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;

  logic                pick_valid;
  logic [GRANT_W-1:0]  pick_idx;
  logic [ADDR_W-1:0]   addr_arr [8];

  // Unpack the flattened address bus, padding unused slots with zero.
  for (genvar i = 0; i < 8; i++) begin : g_addr
    if (i < N_REQ) begin : g_used
      assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    end else begin : g_pad
      assign addr_arr[i] = '0;
    end
  end

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req      (req),
    .rr       (rr_q),
    .prio_en  (1'(PRIO_EN)),
    .prio_req (GRANT_W'(PRIO_REQ)),
    .valid    (pick_valid),
    .index    (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      rr_q    <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      rr_q    <= rr_d;
      wdog_q  <= wdog_d;
    end
  end

  // ack/err are staged on the WAIT exit edge so they are visible during DONE.
  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    rr_d    = rr_q;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE: begin
        if (pick_valid && !sdram_busy) begin
          grant_d = pick_idx;
          addr_d  = addr_arr[pick_idx];
          busy_d  = 1'b1;
          rd_d    = 1'b1;
          wdog_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        wdog_d = wdog_q + WDOG_W'(1);
        if (sdram_dout_ready) begin
          rdata_d = sdram_dout;
          rd_d    = 1'b0;
          ack_d   = N_REQ'(1) << grant_q;
          state_d = DONE;
        end else if (wdog_d == WDOG_W'(TIMEOUT)) begin
          rd_d    = 1'b0;
          err_d   = 1'b1;
          ack_d   = N_REQ'(1) << grant_q;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        wdog_d  = '0;
        rr_d    = (grant_q == GRANT_W'(N_REQ - 1)) ? '0 : grant_q + GRANT_W'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign grant_id   = grant_q;
  assign busy       = busy_q;
  assign sdram_rd   = rd_q;
  assign sdram_addr = addr_q;

endmodule

// File: tb/tb_pgm_sdram_rd_arb.sv
// Directed bench: dut0 is pure round-robin, dut1 has requester 0 as priority.
module tb_pgm_sdram_rd_arb;
  import pgm_mem_pkg::*;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = SDRAM_ADDR_W;
  localparam int unsigned TO = 15;

  logic             clk, reset;
  logic [NR-1:0]    req0, req1;
  logic [NR*AW-1:0] raddr0, raddr1;
  logic [63:0]      dout;
  logic             sbusy, rdy0, rdy1;
  logic [NR-1:0]    ack0, ack1;
  logic [63:0]      rdata0, rdata1;
  logic             err0, err1, busy0, busy1, rd0, rd1;
  logic [2:0]       gid0, gid1;
  logic [AW-1:0]    saddr0, saddr1;

  int checks = 0;
  int errors = 0;

  pgm_sdram_rd_arb #(.N_REQ(NR), .ADDR_W(AW), .PRIO_REQ(0), .PRIO_EN(0), .TIMEOUT(TO)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .req_addr(raddr0), .ack(ack0), .rdata(rdata0),
    .err(err0), .grant_id(gid0), .busy(busy0), .sdram_rd(rd0), .sdram_addr(saddr0),
    .sdram_dout(dout), .sdram_busy(sbusy), .sdram_dout_ready(rdy0));

  pgm_sdram_rd_arb #(.N_REQ(NR), .ADDR_W(AW), .PRIO_REQ(0), .PRIO_EN(1), .TIMEOUT(TO)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .req_addr(raddr1), .ack(ack1), .rdata(rdata1),
    .err(err1), .grant_id(gid1), .busy(busy1), .sdram_rd(rd1), .sdram_addr(saddr1),
    .sdram_dout(dout), .sdram_busy(sbusy), .sdram_dout_ready(rdy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Memory-side responder: waits for the strobe, answers after lat cycles.
  task automatic serve(input bit sel, input int lat, input logic [63:0] data,
                       output logic [2:0] g, output logic [NR-1:0] a,
                       output logic e, output bit ok);
    ok = 1'b0; g = '0; a = '0; e = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((sel ? rd1 : rd0) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      g = sel ? gid1 : gid0;
      for (int i = 1; i < lat; i++) @(negedge clk);
      dout = data;
      if (sel) rdy1 = 1'b1; else rdy0 = 1'b1;
      @(negedge clk);
      a = sel ? ack1 : ack0;
      e = sel ? err1 : err0;
      rdy0 = 1'b0;
      rdy1 = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ack0, err0, busy0, rd0, gid0} !== '0 || rdata0 !== 64'h0 || saddr0 !== '0) begin
      errors++;
      $display("FAIL reset_dut0: ack=%b err=%b busy=%b rd=%b gid=%0d rdata=%h addr=%h want all 0",
               ack0, err0, busy0, rd0, gid0, rdata0, saddr0);
    end
    checks++;
    if ({ack1, err1, busy1, rd1, gid1} !== '0 || rdata1 !== 64'h0 || saddr1 !== '0) begin
      errors++;
      $display("FAIL reset_dut1: ack=%b err=%b busy=%b rd=%b gid=%0d want all 0",
               ack1, err1, busy1, rd1, gid1);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    raddr0 = {29'h0000002, 29'h0000001, 29'h0000001};
    raddr0[2*AW +: AW] = W_ROM_BASE + 29'h10;
    raddr0[AW +: AW] = 29'h2;
    req0 = 3'b100;
    @(negedge clk);
    checks++;
    if (rd0 !== 1'b1 || gid0 !== 3'd2 || busy0 !== 1'b1 || saddr0 !== 29'h620010) begin
      errors++;
      $display("FAIL single_grant: rd=%b gid=%0d busy=%b addr=%h want 1 2 1 620010",
               rd0, gid0, busy0, saddr0);
    end
    raddr0[2*AW +: AW] = 29'h0ABCDE;
    @(negedge clk);
    checks++;
    if (saddr0 !== 29'h620010) begin
      errors++;
      $display("FAIL single_addr_hold: got %h want 620010", saddr0);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ack0 !== 3'b000 || rd0 !== 1'b1) begin
      errors++;
      $display("FAIL single_pre_ack: ack=%b rd=%b want 000 1", ack0, rd0);
    end
    dout = 64'hDEADBEEF_CAFEF00D;
    rdy0 = 1'b1;
    @(negedge clk);
    checks++;
    if (ack0 !== 3'b100 || err0 !== 1'b0 || rdata0 !== 64'hDEADBEEF_CAFEF00D
        || rd0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL single_ack: ack=%b err=%b rdata=%h rd=%b busy=%b want 100 0 deadbeefcafef00d 0 1",
               ack0, err0, rdata0, rd0, busy0);
    end
    rdy0 = 1'b0;
    req0 = 3'b000;
    @(negedge clk);
    checks++;
    if (ack0 !== 3'b000 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL single_after: ack=%b busy=%b want 000 0", ack0, busy0);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] g, prev;
    logic [NR-1:0] a;
    logic e;
    bit ok;
    prev = 3'd7;
    req0 = 3'b111;
    for (int k = 0; k < 6; k++) begin
      serve(1'b0, 2, 64'hA0 + 64'(k), g, a, e, ok);
      checks++;
      if (!ok || g !== 3'(k % 3) || g === prev || a !== (3'b001 << (k % 3)) || e !== 1'b0
          || rdata0 !== 64'hA0 + 64'(k)) begin
        errors++;
        $display("FAIL rr_grant_%0d: ok=%b gid=%0d ack=%b err=%b rdata=%h want 1 %0d %b 0 %h",
                 k, ok, g, a, e, rdata0, k % 3, 3'b001 << (k % 3), 64'hA0 + 64'(k));
      end
      prev = g;
    end
    req0 = 3'b000;
  endtask

  task automatic test_priority();
    logic [2:0] g;
    logic [NR-1:0] a;
    logic e;
    bit ok;
    raddr1 = '0;
    req1 = 3'b110;
    @(negedge clk);
    checks++;
    if (rd1 !== 1'b1 || gid1 !== 3'd1) begin
      errors++;
      $display("FAIL prio_first: rd=%b gid=%0d want 1 1", rd1, gid1);
    end
    @(negedge clk);
    req1 = 3'b111;
    @(negedge clk);
    checks++;
    if (rd1 !== 1'b1 || gid1 !== 3'd1) begin
      errors++;
      $display("FAIL prio_no_preempt: rd=%b gid=%0d want 1 1", rd1, gid1);
    end
    dout = 64'h11;
    rdy1 = 1'b1;
    @(negedge clk);
    checks++;
    if (ack1 !== 3'b010 || rdata1 !== 64'h11) begin
      errors++;
      $display("FAIL prio_ack1: ack=%b rdata=%h want 010 11", ack1, rdata1);
    end
    rdy1 = 1'b0;
    req1 = 3'b101;
    serve(1'b1, 2, 64'h22, g, a, e, ok);
    checks++;
    if (!ok || g !== 3'd0 || a !== 3'b001) begin
      errors++;
      $display("FAIL prio_wins: ok=%b gid=%0d ack=%b want 1 0 001", ok, g, a);
    end
    req1 = 3'b100;
    serve(1'b1, 2, 64'h33, g, a, e, ok);
    checks++;
    if (!ok || g !== 3'd2 || a !== 3'b100 || rdata1 !== 64'h33) begin
      errors++;
      $display("FAIL prio_then2: ok=%b gid=%0d ack=%b rdata=%h want 1 2 100 33", ok, g, a, rdata1);
    end
    req1 = 3'b000;
  endtask

  task automatic test_timeout();
    logic [2:0] g;
    logic [NR-1:0] a;
    logic e;
    bit ok, hi;
    req0 = 3'b010;
    dout = 64'hBAD0;
    @(negedge clk);
    checks++;
    if (rd0 !== 1'b1 || gid0 !== 3'd1) begin
      errors++;
      $display("FAIL to_grant: rd=%b gid=%0d want 1 1", rd0, gid0);
    end
    hi = 1'b1;
    for (int i = 2; i <= 15; i++) begin
      @(negedge clk);
      if (rd0 !== 1'b1 || ack0 !== 3'b000 || err0 !== 1'b0) hi = 1'b0;
    end
    checks++;
    if (hi !== 1'b1) begin
      errors++;
      $display("FAIL to_rd_held: rd dropped or ack/err early, flag=%b want 1", hi);
    end
    @(negedge clk);
    checks++;
    if (rd0 !== 1'b0 || ack0 !== 3'b010 || err0 !== 1'b1 || rdata0 !== 64'hA5 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL to_abort: rd=%b ack=%b err=%b rdata=%h busy=%b want 0 010 1 a5 1",
               rd0, ack0, err0, rdata0, busy0);
    end
    req0 = 3'b100;
    @(negedge clk);
    checks++;
    if (ack0 !== 3'b000 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL to_err_pulse: ack=%b err=%b want 000 0", ack0, err0);
    end
    serve(1'b0, 2, 64'h77, g, a, e, ok);
    checks++;
    if (!ok || g !== 3'd2 || a !== 3'b100 || e !== 1'b0 || rdata0 !== 64'h77) begin
      errors++;
      $display("FAIL to_next: ok=%b gid=%0d ack=%b err=%b rdata=%h want 1 2 100 0 77",
               ok, g, a, e, rdata0);
    end
    req0 = 3'b000;
  endtask

  task automatic test_timeout_boundary();
    logic [2:0] g;
    logic [NR-1:0] a;
    logic e;
    bit ok;
    req0 = 3'b001;
    serve(1'b0, 15, 64'hF15, g, a, e, ok);
    checks++;
    if (!ok || g !== 3'd0 || a !== 3'b001 || e !== 1'b0 || rdata0 !== 64'hF15) begin
      errors++;
      $display("FAIL to_edge_ready: ok=%b gid=%0d ack=%b err=%b rdata=%h want 1 0 001 0 f15",
               ok, g, a, e, rdata0);
    end
    req0 = 3'b000;
  endtask

  task automatic test_busy_gate();
    logic [2:0] g;
    logic [NR-1:0] a;
    logic e;
    bit ok, stay;
    sbusy = 1'b1;
    req0 = 3'b001;
    stay = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rd0 !== 1'b0 || busy0 !== 1'b0) stay = 1'b0;
    end
    checks++;
    if (stay !== 1'b1) begin
      errors++;
      $display("FAIL busy_gate_hold: grant while sdram_busy, flag=%b want 1", stay);
    end
    sbusy = 1'b0;
    @(negedge clk);
    checks++;
    if (rd0 !== 1'b1 || gid0 !== 3'd0) begin
      errors++;
      $display("FAIL busy_gate_release: rd=%b gid=%0d want 1 0", rd0, gid0);
    end
    serve(1'b0, 1, 64'hB0B, g, a, e, ok);
    checks++;
    if (!ok || a !== 3'b001 || rdata0 !== 64'hB0B) begin
      errors++;
      $display("FAIL busy_gate_ack: ok=%b ack=%b rdata=%h want 1 001 b0b", ok, a, rdata0);
    end
    req0 = 3'b000;
  endtask

  task automatic test_idle_ready();
    @(negedge clk);
    dout = 64'hEEEE;
    rdy0 = 1'b1;
    @(negedge clk);
    checks++;
    if (ack0 !== 3'b000 || rdata0 !== 64'hB0B || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: ack=%b rdata=%h busy=%b want 000 b0b 0", ack0, rdata0, busy0);
    end
    rdy0 = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    bit noack;
    raddr0[AW +: AW] = 29'h1234;
    req0 = 3'b010;
    @(negedge clk);
    checks++;
    if (rd0 !== 1'b1 || saddr0 !== 29'h1234) begin
      errors++;
      $display("FAIL rst_mid_grant: rd=%b addr=%h want 1 1234", rd0, saddr0);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ack0, err0, busy0, rd0, gid0} !== '0 || rdata0 !== 64'h0 || saddr0 !== '0) begin
      errors++;
      $display("FAIL rst_async: ack=%b err=%b busy=%b rd=%b gid=%0d rdata=%h addr=%h want all 0",
               ack0, err0, busy0, rd0, gid0, rdata0, saddr0);
    end
    @(negedge clk);
    reset = 1'b0;
    req0 = 3'b000;
    rdy0 = 1'b1;
    noack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rdy0 = 1'b0;
      if (ack0 !== 3'b000 || err0 !== 1'b0 || busy0 !== 1'b0) noack = 1'b0;
    end
    checks++;
    if (noack !== 1'b1) begin
      errors++;
      $display("FAIL rst_no_ack: ack or busy seen after reset, flag=%b want 1", noack);
    end
  endtask

  initial begin
    reset = 1'b1;
    req0 = '0; req1 = '0;
    raddr0 = '0; raddr1 = '0;
    dout = '0; sbusy = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_timeout();
    test_timeout_boundary();
    test_busy_gate();
    test_idle_ready();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pgm_sdram_rd_arb.md
Name: pgm_sdram_rd_arb

Overview:
- Shares the single 64-bit SDRAM sample/ROM read port between up to N_REQ requesters: the ICS2115 TDM fetch, the Z80 sound-ROM fetch and the 68K program fetch.
- Sits between the requesters' level-held rd/addr interfaces and the SDRAM controller read channel.
- Arbitrates round-robin with an optional fixed-priority override, allows one outstanding read, returns registered data with a one-cycle ack, and recovers from a stalled SDRAM via a watchdog.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- ADDR_W, 29, word address width, matching sdram_addr.
- PRIO_REQ, 0, index of the requester that always wins when PRIO_EN=1.
- PRIO_EN, 0, 1 = PRIO_REQ has absolute priority; 0 = pure round-robin.
- TIMEOUT, 1023, maximum cycles spent in WAIT before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester read request, level, held until ack.
- req_addr  in  N_REQ*ADDR_W  flattened addresses; slice i belongs to req[i].
- ack  out  N_REQ  one-cycle pulse to the owner when rdata is valid or the read aborted.
- rdata  out  64  registered read data.
- err  out  1  pulses together with ack when the read aborted on timeout.
- grant_id  out  3  index of the current owner; valid while busy=1.
- busy  out  1  high from grant until the ack cycle, inclusive.
- sdram_rd  out  1  read strobe to the SDRAM controller, level.
- sdram_addr  out  ADDR_W  latched address of the owner.
- sdram_dout  in  64  SDRAM read data.
- sdram_busy  in  1  controller busy; no new read may start while it is high.
- sdram_dout_ready  in  1  one-cycle pulse: sdram_dout is valid.

Behaviour:
- Reset (async, high): state=IDLE; ack=0, err=0, rdata=0, grant_id=0, busy=0, sdram_rd=0, sdram_addr=0, rr pointer=0, watchdog=0. Reset mid-read abandons the read; no ack is issued.
- IDLE
  - If any req is high and sdram_busy=0: choose the winner, latch sdram_addr=req_addr[winner] and grant_id=winner, set busy=1 and sdram_rd=1, go to WAIT.
  - Winner with PRIO_EN=1 and req[PRIO_REQ]=1: PRIO_REQ.
  - Otherwise: the first requesting index at or after rr, wrapping N_REQ-1 -> 0.
  - If sdram_busy=1: stay in IDLE with no grant.
- WAIT
  - sdram_rd stays high and the watchdog increments each cycle.
  - On sdram_dout_ready=1: rdata<=sdram_dout, sdram_rd<=0, go to DONE.
  - If the watchdog reaches TIMEOUT without sdram_dout_ready: sdram_rd<=0, rdata unchanged, err flag set, go to DONE.
  - A sdram_dout_ready arriving in the same cycle as the timeout counts as success (no err).
- DONE (one cycle)
  - ack[grant_id]=1; err=1 only on an abort.
  - rr<=(grant_id+1) mod N_REQ; watchdog<=0; busy falls next cycle; go to IDLE.
- Latency:
  - Grant is registered on the cycle after req is seen in IDLE.
  - ack comes 1 cycle after the cycle in which sdram_dout_ready was sampled.
  - Minimum req-to-ack is 3 cycles when the controller answers on its first possible cycle.
- Requester contract: req must drop in the cycle after ack. A req still high in IDLE after DONE is treated as a new request and is arbitrated against the others with the rotated rr, so there are no back-to-back wins under contention.
- The latched address does not change if req_addr changes mid-transfer. A req that drops mid-transfer still completes, and ack is still pulsed.
- A sdram_dout_ready seen in IDLE or DONE is ignored.
- Only one ack bit is ever high at a time; ack and err are never high outside DONE.

Decomposition:
- Shared package pgm_mem_pkg holds:
  - SDRAM_ADDR_W=29 and the requester index constants REQ_68K=0, REQ_Z80=1, REQ_ICS=2;
  - the W-ROM base 29'h620000;
  - the state enum {IDLE, WAIT, DONE}.
- One sub-module, rr_pick: combinational round-robin selector taking (req, rr, prio_en, prio_req) and returning (valid, index). It is reused by the future video-fetch arbiter.

Test Plan:
- Single request: req[2]=1, req_addr[2]=29'h620010, the SDRAM model answers dout_ready 4 cycles after rd with 64'hDEADBEEF_CAFEF00D -> sdram_addr=29'h620010, ack=3'b100 exactly one cycle after ready, rdata matches, err=0.
- Round-robin: all three reqs held continuously with 2-cycle memory latency -> grant order 0,1,2,0,1,2 with no index granted twice in a row.
- Priority: PRIO_EN=1, PRIO_REQ=0; req[1] and req[2] held, and req[0] pulsed during a read for req[1] -> the next grant goes to 0, then 2; the read in progress is not pre-empted.
- Timeout: TIMEOUT=15 and the model never asserts ready -> sdram_rd drops after 15 WAIT cycles, ack and err pulse together, rdata is unchanged, and the next requester is served normally.
- Busy gate and reset: sdram_busy=1 with req[0] high -> no grant until busy falls, then grant the next cycle. Assert reset asynchronously mid-WAIT -> all outputs go to 0 immediately and no ack follows.
